// File: rtl/md_unit_param_if.sv
// Handshake bundle between the E stage and the multiply/divide unit.
interface md_unit_param_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             req;
    logic             busy;
    logic [WIDTH-1:0] mdr;

    modport master (output start, op, src_a, src_b, req, input busy, mdr);
    modport slave  (input start, op, src_a, src_b, req, output busy, mdr);
endinterface

// File: rtl/md_unit_param.sv
// Multi-cycle multiply/divide unit with HI/LO, accumulate ops and M-stage abort.
// Result is computed from latched operands and committed after a fixed latency.
module md_unit_param #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input logic           clk,
    input logic           reset,
    md_unit_param_if.slave md
);
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);
    localparam logic [CW-1:0]    MUL_END = CW'(MUL_LAT);
    localparam logic [CW-1:0]    DIV_END = CW'(DIV_LAT);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;
    typedef enum logic [3:0] {
        OP_MULT  = 4'b0000, OP_MULTU = 4'b0001, OP_DIV   = 4'b0010, OP_DIVU  = 4'b0011,
        OP_MFHI  = 4'b0100, OP_MFLO  = 4'b0101, OP_MTHI  = 4'b0110, OP_MTLO  = 4'b0111,
        OP_MADD  = 4'b1000, OP_MADDU = 4'b1001, OP_MSUB  = 4'b1010, OP_MSUBU = 4'b1011
    } op_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [3:0]         op_q, op_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

    logic               is_compute, is_div, signed_op;
    logic [2*WIDTH-1:0] ea, eb, prod, mul_res;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   ua, ub, uq, ur, div_hi, div_lo;

    always_comb begin
        is_compute = 1'b0;
        is_div     = 1'b0;
        case (md.op)
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_compute = 1'b1;
            OP_DIV, OP_DIVU: begin
                is_compute = 1'b1;
                is_div     = 1'b1;
            end
            default: ;
        endcase
    end

    // Sign-extending to 2*WIDTH lets one unsigned multiply serve both signednesses.
    always_comb begin
        signed_op = (op_q == OP_MULT) || (op_q == OP_DIV) || (op_q == OP_MADD) || (op_q == OP_MSUB);
        ea   = signed_op ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        eb   = signed_op ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
        prod = ea * eb;
        case (op_q)
            OP_MADD, OP_MADDU: mul_res = acc_q + prod;
            OP_MSUB, OP_MSUBU: mul_res = acc_q - prod;
            default:           mul_res = prod;
        endcase
    end

    always_comb begin
        a_neg = signed_op & a_q[WIDTH-1];
        b_neg = signed_op & b_q[WIDTH-1];
        ua    = a_neg ? -a_q : a_q;
        ub    = b_neg ? -b_q : b_q;
        uq    = (ub == '0) ? '0 : ua / ub;
        ur    = (ub == '0) ? '0 : ua % ub;
        if (b_q == '0) begin
            div_lo = '1;
            div_hi = a_q;
        end else if (signed_op && a_q == MIN_VAL && b_q == '1) begin
            div_lo = MIN_VAL;
            div_hi = '0;
        end else begin
            div_lo = (a_neg ^ b_neg) ? -uq : uq;
            div_hi = a_neg ? -ur : ur;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (!md.req) begin
                    if (md.start && is_compute) begin
                        a_d     = md.src_a;
                        b_d     = md.src_b;
                        op_d    = md.op;
                        acc_d   = {hi_q, lo_q};
                        cnt_d   = CW'(1);
                        state_d = is_div ? S_DIV : S_MUL;
                    end else if (md.op == OP_MTHI) begin
                        hi_d = md.src_a;
                    end else if (md.op == OP_MTLO) begin
                        lo_d = md.src_a;
                    end
                end
            end
            S_MUL: begin
                if (md.req) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == MUL_END) begin
                    {hi_d, lo_d} = mul_res;
                    state_d      = S_IDLE;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DIV: begin
                if (md.req) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DIV_END) begin
                    hi_d    = div_hi;
                    lo_d    = div_lo;
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign md.busy = (state_q != S_IDLE);
    assign md.mdr  = (md.op == OP_MFHI) ? hi_q : (md.op == OP_MFLO) ? lo_q : '0;
endmodule
